// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB pipeline register: default widths,
// skid-buffer occupancy encoding and the packed write-back entry.
package mem_wb_stage_pkg;

  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_ADDR_W = 5;

  // Encoding is {head_valid, skid_valid}; 2'b01 is unreachable by construction.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_TWO   = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic                    wreg;
    logic [MEMWB_ADDR_W-1:0] rd_addr;
    logic [MEMWB_DATA_W-1:0] data;
  } memwb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle between the MEM stage, the MEM/WB register and the regfile write port.
// The master modport is the surrounding pipeline; the slave modport is the stage.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int ADDR_W = MEMWB_ADDR_W
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and in_ready_o never looks at out_ready_i.
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;

  logic              fwd_valid_o;
  logic [ADDR_W-1:0] fwd_rd_addr_o;
  logic [DATA_W-1:0] fwd_wdata_o;

  skid_state_e       dbg_state;

  modport master (
    output flush_i, in_valid_i, rd_addr_i, wreg_i, wdata_i, out_ready_i,
    input  in_ready_o, out_valid_o, rd_addr_o, wreg_o, wdata_o,
    input  fwd_valid_o, fwd_rd_addr_o, fwd_wdata_o, dbg_state
  );

  modport slave (
    input  flush_i, in_valid_i, rd_addr_i, wreg_i, wdata_i, out_ready_i,
    output in_ready_o, out_valid_o, rd_addr_o, wreg_o, wdata_o,
    output fwd_valid_o, fwd_rd_addr_o, fwd_wdata_o, dbg_state
  );

endinterface

// File: rtl/mem_wb_stage_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. Head (H) drives the output,
// skid (S) absorbs one extra entry so in_ready depends only on registered state.
module pipe_skid_buf
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             skid_valid,
  output logic [WIDTH-1:0] skid_data,
  output skid_state_e      state
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic [1:0]       state_bits;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] s_q;
  logic             accept;
  logic             pop;
  logic             load_h;
  logic             load_s;
  logic             move_s;

  assign state_bits = state_q;
  assign out_valid  = state_bits[1];
  assign skid_valid = state_bits[0];
  assign in_ready   = !skid_valid && !rst;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_data   = h_q;
  assign skid_data  = s_q;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    load_h  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          load_h  = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          load_h = 1'b1;
        end else if (accept) begin
          state_d = SKID_TWO;
          load_s  = 1'b1;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d = SKID_ONE;
          move_s  = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // A pop still retires the head this cycle; everything else is dropped.
    if (flush) begin
      state_d = SKID_EMPTY;
      load_h  = 1'b0;
      load_s  = 1'b0;
      move_s  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_h) begin
        h_q <= in_data;
      end else if (move_s) begin
        h_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_data;
      end
    end
  end

  a_no_skid_without_head: assert property (
    @(posedge clk) disable iff (rst) !(!out_valid && skid_valid)
  );

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: skid-buffered handshake, flush, x0 write
// suppression and a bypass port exposing the youngest held register write.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W        = MEMWB_DATA_W,
  parameter int ADDR_W        = MEMWB_ADDR_W,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  localparam int PW = 1 + ADDR_W + DATA_W;

  logic              wreg_cap;
  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     h_payload;
  logic [PW-1:0]     s_payload;
  logic              h_v;
  logic              s_v;
  logic              in_ready;

  logic              h_wreg;
  logic [ADDR_W-1:0] h_rd;
  logic [DATA_W-1:0] h_data;
  logic              s_wreg;
  logic [ADDR_W-1:0] s_rd;
  logic [DATA_W-1:0] s_data;

  // Writes to x0 still flow through so WB sees the retirement, just without wreg.
  assign wreg_cap   = bus.wreg_i && !(ZERO_SUPPRESS && (bus.rd_addr_i == '0));
  assign in_payload = {wreg_cap, bus.rd_addr_i, bus.wdata_i};

  pipe_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush_i),
    .in_valid   (bus.in_valid_i),
    .in_ready   (in_ready),
    .in_data    (in_payload),
    .out_valid  (h_v),
    .out_ready  (bus.out_ready_i),
    .out_data   (h_payload),
    .skid_valid (s_v),
    .skid_data  (s_payload),
    .state      (bus.dbg_state)
  );

  assign h_wreg = h_payload[PW-1];
  assign h_rd   = h_payload[DATA_W +: ADDR_W];
  assign h_data = h_payload[DATA_W-1:0];
  assign s_wreg = s_payload[PW-1];
  assign s_rd   = s_payload[DATA_W +: ADDR_W];
  assign s_data = s_payload[DATA_W-1:0];

  // Reset is synchronous, so outputs are forced quiet during the reset cycle too.
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = h_v && !rst;
  assign bus.wreg_o      = h_v && h_wreg && !rst;
  assign bus.rd_addr_o   = rst ? '0 : h_rd;
  assign bus.wdata_o     = rst ? '0 : h_data;

  // S is always younger than H, so it wins when both write.
  always_comb begin
    bus.fwd_valid_o   = 1'b0;
    bus.fwd_rd_addr_o = '0;
    bus.fwd_wdata_o   = '0;
    if (!rst) begin
      if (s_v && s_wreg) begin
        bus.fwd_valid_o   = 1'b1;
        bus.fwd_rd_addr_o = s_rd;
        bus.fwd_wdata_o   = s_data;
      end else if (h_v && h_wreg) begin
        bus.fwd_valid_o   = 1'b1;
        bus.fwd_rd_addr_o = h_rd;
        bus.fwd_wdata_o   = h_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal
// expectations plus a queue model compared against the outputs every cycle.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int W = $bits(memwb_entry_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(MEMWB_DATA_W), .ADDR_W(MEMWB_ADDR_W)) bus_if ();

  mem_wb_stage #(
    .DATA_W        (MEMWB_DATA_W),
    .ADDR_W        (MEMWB_ADDR_W),
    .ZERO_SUPPRESS (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          wb_count = 0;
  bit          done     = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the stage is a FIFO of at most two entries.
  always begin : scoreboard
    memwb_entry_t head;
    memwb_entry_t fw;
    memwb_entry_t e;
    memwb_entry_t tmp;
    logic         e_ready;
    logic         e_valid;
    logic         e_fwv;
    logic         acc;
    logic         pop;
    @(negedge clk);
    if (!done) begin
      head    = '0;
      fw      = '0;
      e_fwv   = 1'b0;
      e_ready = 1'b0;
      e_valid = 1'b0;
      if (!rst) begin
        e_ready = (exp_q.size() < 2);
        e_valid = (exp_q.size() > 0);
        if (e_valid) head = exp_q[0];
        for (int i = 0; i < exp_q.size(); i++) begin
          tmp = exp_q[i];
          if (tmp.wreg) begin
            fw    = tmp;
            e_fwv = 1'b1;
          end
        end
      end
      check("in_ready", 64'(bus_if.in_ready_o), 64'(e_ready));
      check("out_valid", 64'(bus_if.out_valid_o), 64'(e_valid));
      check("wreg_o", 64'(bus_if.wreg_o), 64'(head.wreg));
      if (rst || e_valid) begin
        check("rd_addr_o", 64'(bus_if.rd_addr_o), 64'(head.rd_addr));
        check("wdata_o", bus_if.wdata_o, head.data);
      end
      check("fwd_valid", 64'(bus_if.fwd_valid_o), 64'(e_fwv));
      check("fwd_rd_addr", 64'(bus_if.fwd_rd_addr_o), 64'(fw.rd_addr));
      check("fwd_wdata", bus_if.fwd_wdata_o, fw.data);

      // Inputs are stable from here to the next rising edge.
      if (rst) begin
        exp_q.delete();
      end else begin
        acc = bus_if.in_valid_i && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && bus_if.out_ready_i;
        if (pop) begin
          void'(exp_q.pop_front());
          wb_count++;
        end
        if (bus_if.flush_i) begin
          exp_q.delete();
        end else if (acc) begin
          e.wreg    = bus_if.wreg_i && (bus_if.rd_addr_i != '0);
          e.rd_addr = bus_if.rd_addr_i;
          e.data    = bus_if.wdata_i;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] rd, input logic w, input logic [63:0] d);
    bus_if.in_valid_i = v;
    bus_if.rd_addr_i  = rd;
    bus_if.wreg_i     = w;
    bus_if.wdata_i    = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus_if.flush_i     = 1'b0;
    bus_if.out_ready_i = 1'b0;
    offer(1'b0, 5'd0, 1'b0, 64'h0);

    // Reset
    tick();
    check("rst_in_ready", 64'(bus_if.in_ready_o), 64'd0);
    check("rst_out_valid", 64'(bus_if.out_valid_o), 64'd0);
    check("rst_fwd_valid", 64'(bus_if.fwd_valid_o), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus_if.in_ready_o), 64'd1);

    // Stream of three entries with WB always ready
    bus_if.out_ready_i = 1'b1;
    offer(1'b1, 5'd1, 1'b1, 64'h11);
    tick();
    check("s1_rd", 64'(bus_if.rd_addr_o), 64'd1);
    check("s1_data", bus_if.wdata_o, 64'h11);
    check("s1_ready", 64'(bus_if.in_ready_o), 64'd1);
    offer(1'b1, 5'd2, 1'b1, 64'h22);
    tick();
    check("s2_rd", 64'(bus_if.rd_addr_o), 64'd2);
    check("s2_ready", 64'(bus_if.in_ready_o), 64'd1);
    offer(1'b1, 5'd3, 1'b1, 64'h33);
    tick();
    check("s3_data", bus_if.wdata_o, 64'h33);
    check("s3_wreg", 64'(bus_if.wreg_o), 64'd1);
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    tick();
    check("s_drain_valid", 64'(bus_if.out_valid_o), 64'd0);

    // Back-pressure fills head and skid
    bus_if.out_ready_i = 1'b0;
    offer(1'b1, 5'd4, 1'b1, 64'hAA);
    tick();
    check("bp1_ready", 64'(bus_if.in_ready_o), 64'd1);
    offer(1'b1, 5'd5, 1'b1, 64'hBB);
    tick();
    check("bp2_ready", 64'(bus_if.in_ready_o), 64'd0);
    check("bp2_fwd_rd", 64'(bus_if.fwd_rd_addr_o), 64'd5);
    check("bp2_fwd_data", bus_if.fwd_wdata_o, 64'hBB);
    check("bp2_head", 64'(bus_if.rd_addr_o), 64'd4);
    offer(1'b1, 5'd6, 1'b1, 64'hCC);
    tick();
    check("bp3_head_data", bus_if.wdata_o, 64'hAA);
    check("bp3_fwd_rd", 64'(bus_if.fwd_rd_addr_o), 64'd5);
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    bus_if.out_ready_i = 1'b1;
    tick();
    check("rel1_data", bus_if.wdata_o, 64'hBB);
    check("rel1_ready", 64'(bus_if.in_ready_o), 64'd1);
    tick();
    check("rel2_valid", 64'(bus_if.out_valid_o), 64'd0);

    // x0 write suppression
    bus_if.out_ready_i = 1'b0;
    offer(1'b1, 5'd0, 1'b1, 64'hFF);
    tick();
    check("x0_valid", 64'(bus_if.out_valid_o), 64'd1);
    check("x0_wreg", 64'(bus_if.wreg_o), 64'd0);
    check("x0_fwd", 64'(bus_if.fwd_valid_o), 64'd0);
    check("x0_data", bus_if.wdata_o, 64'hFF);
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    bus_if.out_ready_i = 1'b1;
    tick();

    // Flush while full, with a pop and a fresh offer in the same cycle
    bus_if.out_ready_i = 1'b0;
    offer(1'b1, 5'd4, 1'b1, 64'h44);
    tick();
    offer(1'b1, 5'd5, 1'b1, 64'h55);
    tick();
    check("fl_full_ready", 64'(bus_if.in_ready_o), 64'd0);
    bus_if.out_ready_i = 1'b1;
    bus_if.flush_i     = 1'b1;
    offer(1'b1, 5'd7, 1'b1, 64'h77);
    #1;
    check("fl_pop_rd", 64'(bus_if.rd_addr_o), 64'd4);
    tick();
    bus_if.flush_i = 1'b0;
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    check("fl_valid", 64'(bus_if.out_valid_o), 64'd0);
    check("fl_fwd", 64'(bus_if.fwd_valid_o), 64'd0);
    check("fl_ready", 64'(bus_if.in_ready_o), 64'd1);
    bus_if.flush_i = 1'b1;
    offer(1'b1, 5'd8, 1'b1, 64'h88);
    tick();
    bus_if.flush_i = 1'b0;
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    check("fl_drop_valid", 64'(bus_if.out_valid_o), 64'd0);

    // Reset mid-operation with two entries held
    bus_if.out_ready_i = 1'b0;
    offer(1'b1, 5'd9, 1'b1, 64'h99);
    tick();
    offer(1'b1, 5'd10, 1'b1, 64'hA0);
    tick();
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    rst = 1'b1;
    #1;
    check("mr_valid", 64'(bus_if.out_valid_o), 64'd0);
    check("mr_ready", 64'(bus_if.in_ready_o), 64'd0);
    check("mr_fwd", 64'(bus_if.fwd_valid_o), 64'd0);
    check("mr_data", bus_if.wdata_o, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_after_valid", 64'(bus_if.out_valid_o), 64'd0);
    check("mr_after_rd", 64'(bus_if.rd_addr_o), 64'd0);
    check("mr_after_data", bus_if.wdata_o, 64'h0);
    bus_if.out_ready_i = 1'b1;
    tick();
    check("mr_idle_valid", 64'(bus_if.out_valid_o), 64'd0);

    // Random traffic against the queue model
    for (int c = 0; c < 10000; c++) begin
      rst                = ($urandom_range(0, 499) == 0);
      bus_if.flush_i     = ($urandom_range(0, 39) == 0);
      bus_if.out_ready_i = ($urandom_range(0, 2) != 0);
      offer(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), {$urandom, $urandom});
      tick();
    end

    rst                = 1'b0;
    bus_if.flush_i     = 1'b0;
    bus_if.out_ready_i = 1'b1;
    offer(1'b0, 5'd0, 1'b0, 64'h0);
    tick();
    tick();
    tick();
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
